// File: rtl/maquina_refrigerantes_param.sv
// Vending controller: accumulates coin credit, vends NUM_PRODUCTS products at a fixed
// PRICE with per-product stock, and returns change one credit unit per cycle.
//
// state   | meaning
// IDLE    | no credit held; restock allowed
// CREDITO | credit > 0, waiting for more coins, purchase or cancel
// VEND    | one-cycle dispense pulse
// TROCO   | returning credit, one unit per cycle
module maquina_refrigerantes_param #(
    parameter int PRICE        = 3,
    parameter int MAX_CREDIT   = 15,
    parameter int COIN_W       = 3,
    parameter int NUM_PRODUCTS = 4,
    parameter int STOCK_W      = 4,
    parameter int STOCK_INIT   = 5,
    localparam int CREDIT_W    = $clog2(MAX_CREDIT + 1),
    localparam int SEL_W       = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                moeda,
    input  logic [COIN_W-1:0]   moeda_valor,
    input  logic                compra,
    input  logic [SEL_W-1:0]    produto,
    input  logic                desiste,
    input  logic                reabastece,
    output logic                refri,
    output logic [SEL_W-1:0]    refri_id,
    output logic                troco,
    output logic                recusa,
    output logic                esgotado,
    output logic [CREDIT_W-1:0] credito,
    output logic                ocupado
);
    localparam int SUM_W = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
    localparam logic [SUM_W-1:0]    MAX_C   = SUM_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [SEL_W:0]      NP_C    = (SEL_W + 1)'(NUM_PRODUCTS);
    localparam logic [STOCK_W-1:0]  INIT_C  = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {IDLE, CREDITO, VEND, TROCO} state_t;

    state_t state, state_nxt;
    logic [STOCK_W-1:0]  stock [NUM_PRODUCTS];
    logic [STOCK_W-1:0]  stock_sel;
    logic [SUM_W-1:0]    soma;
    logic                sel_ok;
    logic [CREDIT_W-1:0] credito_nxt;
    logic [SEL_W-1:0]    refri_id_nxt;
    logic                refri_nxt, troco_nxt, recusa_nxt, esgotado_nxt;
    logic                vend_en, restock_en;

    assign soma      = SUM_W'(credito) + SUM_W'(moeda_valor);
    assign sel_ok    = {1'b0, produto} < NP_C;
    assign stock_sel = sel_ok ? stock[produto] : '0;

    always_comb begin
        state_nxt    = state;
        credito_nxt  = credito;
        refri_nxt    = 1'b0;
        refri_id_nxt = '0;
        troco_nxt    = 1'b0;
        recusa_nxt   = 1'b0;
        esgotado_nxt = 1'b0;
        vend_en      = 1'b0;
        restock_en   = 1'b0;
        case (state)
            IDLE, CREDITO: begin
                restock_en = (state == IDLE) && reabastece;
                // A coin arriving with an acted-on cancel/purchase is bounced back.
                if (desiste && credito != '0) begin
                    state_nxt  = TROCO;
                    troco_nxt  = 1'b1;
                    recusa_nxt = moeda;
                end else if (compra && (!sel_ok || stock_sel == '0)) begin
                    esgotado_nxt = 1'b1;
                    recusa_nxt   = moeda;
                end else if (compra && credito >= PRICE_C) begin
                    state_nxt    = VEND;
                    vend_en      = 1'b1;
                    refri_nxt    = 1'b1;
                    refri_id_nxt = produto;
                    credito_nxt  = credito - PRICE_C;
                    recusa_nxt   = moeda;
                end else if (moeda && moeda_valor != '0) begin
                    if (soma > MAX_C) begin
                        recusa_nxt = 1'b1;
                    end else begin
                        credito_nxt = soma[CREDIT_W-1:0];
                        state_nxt   = CREDITO;
                    end
                end
            end
            VEND: begin
                recusa_nxt = moeda;
                if (credito != '0) begin
                    state_nxt = TROCO;
                    troco_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            TROCO: begin
                // credito counts the units still owed, including the one on troco now.
                recusa_nxt = moeda;
                if (credito <= CREDIT_W'(1)) begin
                    state_nxt   = IDLE;
                    credito_nxt = '0;
                end else begin
                    credito_nxt = credito - CREDIT_W'(1);
                    troco_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                credito_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            credito  <= '0;
            refri    <= 1'b0;
            refri_id <= '0;
            troco    <= 1'b0;
            recusa   <= 1'b0;
            esgotado <= 1'b0;
            ocupado  <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) stock[i] <= INIT_C;
        end else begin
            state    <= state_nxt;
            credito  <= credito_nxt;
            refri    <= refri_nxt;
            refri_id <= refri_id_nxt;
            troco    <= troco_nxt;
            recusa   <= recusa_nxt;
            esgotado <= esgotado_nxt;
            ocupado  <= (state_nxt == VEND) || (state_nxt == TROCO);
            if (restock_en) begin
                for (int i = 0; i < NUM_PRODUCTS; i++) stock[i] <= INIT_C;
            end else if (vend_en) begin
                stock[produto] <= stock[produto] - STOCK_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_maquina_refrigerantes_param.sv
// Scoreboard bench: a transaction-level model predicts every dispense, change, reject
// and sold-out pulse; a monitor pops and checks them as the outputs fire.
module tb_maquina_refrigerantes_param;
    localparam int PRICE = 3, MAXC = 15, NP = 4, SINIT = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       moeda = 1'b0;
    logic [2:0] moeda_valor = '0;
    logic       compra = 1'b0;
    logic [1:0] produto = '0;
    logic       desiste = 1'b0;
    logic       reabastece = 1'b0;
    logic       refri, troco, recusa, esgotado, ocupado;
    logic [1:0] refri_id;
    logic [3:0] credito;

    maquina_refrigerantes_param #(
        .PRICE(PRICE), .MAX_CREDIT(MAXC), .COIN_W(3), .NUM_PRODUCTS(NP),
        .STOCK_W(4), .STOCK_INIT(SINIT)
    ) dut (
        .clock(clock), .reset(reset), .moeda(moeda), .moeda_valor(moeda_valor),
        .compra(compra), .produto(produto), .desiste(desiste), .reabastece(reabastece),
        .refri(refri), .refri_id(refri_id), .troco(troco), .recusa(recusa),
        .esgotado(esgotado), .credito(credito), .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {int cyc; int cred; int id;} ev_t;
    ev_t q_refri[$], q_troco[$], q_recusa[$], q_esg[$];

    int tests = 0, fails = 0;
    bit mon_off = 1'b1;

    int m_credit;
    int m_stock[NP];
    int m_tl[$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm, input int got_cyc, input int want_cyc);
        tests++;
        fails++;
        $display("FAIL %s: seen at cycle %0d, expected at cycle %0d", nm, got_cyc, want_cyc);
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
        q_refri.delete(); q_troco.delete(); q_recusa.delete(); q_esg.delete();
    endtask

    // Predicts the outcome of one sampled input set (edge e) while the machine is idle.
    // m_tl[j] is the expected credit at cycle e+j for busy operations.
    task automatic predict(input bit m, input int v, input bit c, input int p, input bit d,
                           input bit r, input int e, output int busy);
        bit was_idle = (m_credit == 0);
        int rem;
        m_tl.delete();
        if (d && m_credit > 0) begin
            for (int j = m_credit; j >= 0; j--) m_tl.push_back(j);
            for (int j = 0; j < m_credit; j++) q_troco.push_back('{e + j, m_tl[j], 0});
            if (m) q_recusa.push_back('{e, m_credit, 0});
            m_credit = 0;
        end else if (c && (p >= NP || m_stock[p] == 0)) begin
            q_esg.push_back('{e, m_credit, 0});
            if (m) q_recusa.push_back('{e, m_credit, 0});
        end else if (c && m_credit >= PRICE) begin
            m_stock[p]--;
            rem = m_credit - PRICE;
            m_tl.push_back(rem);
            for (int j = rem; j >= 0; j--) m_tl.push_back(j);
            q_refri.push_back('{e, rem, p});
            for (int j = 1; j <= rem; j++) q_troco.push_back('{e + j, m_tl[j], 0});
            if (m) q_recusa.push_back('{e, rem, 0});
            m_credit = 0;
        end else if (m && v > 0) begin
            if (m_credit + v > MAXC) q_recusa.push_back('{e, m_credit, 0});
            else m_credit += v;
        end
        if (r && was_idle) for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
        busy = (m_tl.size() > 0) ? m_tl.size() - 1 : 0;
    endtask

    // One operation; inj=k drops a coin on the k-th busy edge, which must be refused.
    task automatic op(input bit m, input int v, input bit c, input int p, input bit d,
                      input bit r, input int inj);
        int e, busy;
        @(negedge clock);
        moeda = m; moeda_valor = 3'(v); compra = c; produto = 2'(p);
        desiste = d; reabastece = r;
        e = cyc + 1;
        predict(m, v, c, p, d, r, e, busy);
        for (int k = 1; k <= busy; k++) begin
            @(negedge clock);
            chk("ocupado_busy", int'(ocupado), 1);
            moeda = (k == inj);
            moeda_valor = 3'($urandom_range(1, 7));
            compra = 1'($urandom);
            desiste = 1'($urandom);
            reabastece = 1'($urandom);
            produto = 2'($urandom);
            if (k == inj) q_recusa.push_back('{e + k, m_tl[k], 0});
        end
        @(negedge clock);
        moeda = 0; compra = 0; desiste = 0; reabastece = 0;
        chk("credito_after_op", int'(credito), m_credit);
        chk("ocupado_idle", int'(ocupado), 0);
    endtask

    always @(negedge clock) begin
        ev_t ev;
        if (!mon_off) begin
            if (refri) begin
                if (q_refri.size() == 0) flag("refri_unexpected", cyc, -1);
                else begin
                    ev = q_refri.pop_front();
                    chk("refri_cycle", cyc, ev.cyc);
                    chk("refri_credito", int'(credito), ev.cred);
                    chk("refri_id", int'(refri_id), ev.id);
                end
            end
            if (esgotado) begin
                if (q_esg.size() == 0) flag("esgotado_unexpected", cyc, -1);
                else begin
                    ev = q_esg.pop_front();
                    chk("esgotado_cycle", cyc, ev.cyc);
                    chk("esgotado_credito", int'(credito), ev.cred);
                end
            end
            if (troco) begin
                if (q_troco.size() == 0) flag("troco_unexpected", cyc, -1);
                else begin
                    ev = q_troco.pop_front();
                    chk("troco_cycle", cyc, ev.cyc);
                    chk("troco_credito", int'(credito), ev.cred);
                end
            end
            if (recusa) begin
                if (q_recusa.size() == 0) flag("recusa_unexpected", cyc, -1);
                else begin
                    ev = q_recusa.pop_front();
                    chk("recusa_cycle", cyc, ev.cyc);
                    chk("recusa_credito", int'(credito), ev.cred);
                end
            end
            if (q_refri.size() > 0 && q_refri[0].cyc < cyc) begin
                flag("refri_missed", -1, q_refri[0].cyc); void'(q_refri.pop_front());
            end
            if (q_esg.size() > 0 && q_esg[0].cyc < cyc) begin
                flag("esgotado_missed", -1, q_esg[0].cyc); void'(q_esg.pop_front());
            end
            if (q_troco.size() > 0 && q_troco[0].cyc < cyc) begin
                flag("troco_missed", -1, q_troco[0].cyc); void'(q_troco.pop_front());
            end
            if (q_recusa.size() > 0 && q_recusa[0].cyc < cyc) begin
                flag("recusa_missed", -1, q_recusa[0].cyc); void'(q_recusa.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, busy;
        model_reset();
        #12;
        chk("reset_credito", int'(credito), 0);
        chk("reset_refri", int'(refri), 0);
        chk("reset_troco", int'(troco), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        reset = 1'b1;
        mon_off = 1'b0;

        // Coins 1,2 then buy product 2 with exact credit.
        op(1, 1, 0, 0, 0, 0, 0);
        chk("credit_after_1", int'(credito), 1);
        op(1, 2, 0, 0, 0, 0, 0);
        chk("credit_after_3", int'(credito), 3);
        op(0, 0, 1, 2, 0, 0, 0);
        // Credit 10, buy product 0: 7 units of change.
        op(1, 5, 0, 0, 0, 0, 0);
        op(1, 5, 0, 0, 0, 0, 0);
        op(0, 0, 1, 0, 0, 0, 0);
        // Saturation at MAX_CREDIT, then cancel 15.
        op(1, 5, 0, 0, 0, 0, 0);
        op(1, 5, 0, 0, 0, 0, 0);
        op(1, 4, 0, 0, 0, 0, 0);
        op(1, 2, 0, 0, 0, 0, 0);
        chk("credit_held_14", int'(credito), 14);
        op(1, 1, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0);
        // Drain product 1, sold-out keeps credit, restock only when idle.
        for (int i = 0; i < 5; i++) begin
            op(1, 3, 0, 0, 0, 0, 0);
            op(0, 0, 1, 1, 0, 0, 0);
        end
        op(1, 3, 0, 0, 0, 0, 0);
        op(0, 0, 1, 1, 0, 0, 0);
        op(0, 0, 0, 0, 0, 1, 0);
        op(0, 0, 1, 1, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0);
        op(0, 0, 0, 0, 0, 1, 0);
        op(1, 3, 0, 0, 0, 0, 0);
        op(0, 0, 1, 1, 0, 0, 0);
        // Coin together with a purchase is refused; coin during change is refused.
        op(1, 3, 0, 0, 0, 0, 0);
        op(1, 2, 1, 3, 0, 0, 0);
        op(1, 6, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 3);

        // Reset in the middle of returning change with 3 units left.
        op(1, 7, 0, 0, 0, 0, 0);
        @(negedge clock);
        desiste = 1'b1;
        e = cyc + 1;
        predict(0, 0, 0, 0, 1, 0, e, busy);
        @(negedge clock);
        desiste = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        chk("pre_reset_credito", int'(credito), m_tl[4]);
        chk("pre_reset_troco", int'(troco), 1);
        #1;
        mon_off = 1'b1;
        reset = 1'b0;
        #1;
        chk("async_reset_troco", int'(troco), 0);
        chk("async_reset_credito", int'(credito), 0);
        chk("async_reset_ocupado", int'(ocupado), 0);
        model_reset();
        @(negedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        mon_off = 1'b0;
        chk("post_reset_credito", int'(credito), 0);
        // Every slot back to full stock: five sales succeed, the sixth is sold out.
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < 6; i++) begin
                op(1, 3, 0, 0, 0, 0, 0);
                op(0, 0, 1, p, 0, 0, 0);
            end
            op(0, 0, 0, 0, 1, 0, 0);
        end
        op(0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            op(($urandom_range(0, 9) < 6), $urandom_range(0, 7), ($urandom_range(0, 9) < 3),
               $urandom_range(0, NP - 1), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 9) == 0), $urandom_range(0, 12));
        end

        repeat (3) @(negedge clock);
        chk("pending_events", q_refri.size() + q_troco.size() + q_recusa.size() + q_esg.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/maquina_refrigerantes_param.md
# maquina_refrigerantes_param

Parametrised vending-machine controller: it accumulates coin credit of arbitrary denomination, vends one of `NUM_PRODUCTS` products at a fixed `PRICE`, and tracks per-product stock. Change is returned serially as one `troco` pulse per credit unit. The block sits between the coin acceptor / selection panel and the dispenser / change-hopper drivers, and generalises the 3-coin single-product machine.

## Interface
- `PRICE`, 3, product price in credit units (1..MAX_CREDIT)
- `MAX_CREDIT`, 15, maximum credit held; a coin that would exceed it is rejected
- `COIN_W`, 3, width of `moeda_valor`
- `NUM_PRODUCTS`, 4, number of product slots (>=1)
- `STOCK_W`, 4, width of each stock counter
- `STOCK_INIT`, 5, stock loaded at reset and on restock
- localparams: `CREDIT_W = $clog2(MAX_CREDIT+1)`; `SEL_W = max(1, $clog2(NUM_PRODUCTS))`

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-low
- `moeda`  in  1  coin inserted (1-cycle pulse)
- `moeda_valor`  in  COIN_W  value of the coin, sampled with `moeda`
- `compra`  in  1  purchase request (pulse)
- `produto`  in  SEL_W  product selected, sampled with `compra`
- `desiste`  in  1  cancel; return all credit
- `reabastece`  in  1  reload all stock counters to STOCK_INIT
- `refri`  out  1  dispense pulse
- `refri_id`  out  SEL_W  product being dispensed; valid while `refri`=1
- `troco`  out  1  one credit unit returned per high cycle
- `recusa`  out  1  coin rejected pulse
- `esgotado`  out  1  selected product unavailable pulse
- `credito`  out  CREDIT_W  current credit
- `ocupado`  out  1  high in VEND and TROCO

## Operation
- States: IDLE (credit=0), CREDITO (credit>0), VEND, TROCO. All outputs are registered.
- IDLE/CREDITO, `moeda`=1, `moeda_valor`=v: if v=0, no effect; if credit+v>MAX_CREDIT, pulse `recusa` with credit unchanged; otherwise credit+=v and go to CREDITO. Sum is computed at CREDIT_W+1 bits, so no wrap-around.
- Priority when several inputs are high in one cycle in IDLE/CREDITO: `desiste` > `compra` > `moeda`. Whenever `desiste` or `compra` is acted on, a simultaneous `moeda` is rejected (`recusa`).
- `desiste` with credit>0: go to TROCO. With credit=0: ignored.
- `compra`:
  - If `produto`>=NUM_PRODUCTS or stock[produto]=0: pulse `esgotado`; credit is kept.
  - Else if credit<PRICE: ignored.
  - Else: go to VEND, stock[produto]-=1, credit-=PRICE.
- VEND (exactly 1 cycle): `refri`=1, `refri_id`=produto. Next state is TROCO if the remaining credit is >0, otherwise IDLE.
- TROCO: `troco`=1 each cycle and credit-=1 each cycle. On the cycle credit reaches 0, go to IDLE.
- VEND/TROCO: `moeda` → `recusa`; `compra`, `desiste` and `reabastece` are ignored.
- `reabastece` is honoured only in IDLE. It sets all stock counters to STOCK_INIT.
- Reset (asynchronous, any state, including mid-TROCO):
  - state IDLE, credit 0, all stock STOCK_INIT;
  - `refri`, `refri_id`, `troco`, `recusa`, `esgotado`, `ocupado` = 0.
  - Credit not yet returned is discarded.

## Timing
- Inputs sampled at rising edge N → responses visible in cycle N+1.
- Coin: `credito` updates in cycle N+1; `recusa` is high for cycle N+1 only.
- Purchase: `refri` is high in cycle N+1. With remainder R>0, `troco` is high for cycles N+2..N+1+R. `credito` shows the remainder in N+1, then decrements once per cycle.
- Cancel with credit C: `troco` is high for cycles N+1..N+C; `credito`=0 and state IDLE after edge N+C.
- `esgotado` is a single-cycle pulse in N+1.
- `ocupado` = (state is VEND or TROCO).
- A new coin is accepted on the first edge at which state is IDLE.

## Test plan
- Reset, then coins 1,2 → `credito`=1 then 3. `compra` with `produto`=2 → `refri`=1, `refri_id`=2 for one cycle, no `troco`, IDLE, stock[2]=4.
- Coins 5,5 (credit 10), then `compra` `produto`=0 → `refri` pulse, then `troco` high exactly 7 consecutive cycles, `credito` 7→0, `ocupado` high 8 cycles.
- Credit 14, coin 2 → `recusa` pulse, `credito` stays 14. Coin 1 → 15. `desiste` → 15 `troco` pulses.
- Five purchases of product 1 succeed; the 6th → `esgotado` pulse, credit retained. `reabastece` is ignored while in CREDITO. `desiste`, then `reabastece` in IDLE → the next purchase of product 1 succeeds.
- Same-cycle `moeda`(v=2)+`compra` with credit 3 → vend proceeds and `recusa` pulses. `moeda` during TROCO → `recusa`, credit unaffected.
- Assert `reset`=0 mid-TROCO (3 units left) → `troco`=0 and `credito`=0 immediately. After release, the block is IDLE with all stock at 5.
